// File: rtl/fcvt_pkg.sv
// Shared constants and the response entry layout for the ftoi arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fcvt_pkg;

  localparam logic REQ_CORE  = 1'b0;
  localparam logic REQ_AUX   = 1'b1;
  localparam int   DEPTH_DEF = 4;
  localparam int   TAG_W     = 4;

  // One response FIFO entry; the tag field is sized for the widest supported tag.
  typedef struct packed {
    logic [31:0]      data;
    logic             id;
    logic [TAG_W-1:0] tag;
  } rsp_entry_t;

endpackage

// File: rtl/fcvt_arbiter_if.sv
// Request/response bundle between the two requesters, the consumer and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both request ports and on the response port.
interface fcvt_arbiter_if
  import fcvt_pkg::*;
#(
  parameter int TAGW = TAG_W
);

  logic            req0_valid;
  logic            req0_ready;
  logic [31:0]     req0_data;
  logic [TAGW-1:0] req0_tag;
  logic            req1_valid;
  logic            req1_ready;
  logic [31:0]     req1_data;
  logic [TAGW-1:0] req1_tag;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic            rsp_id;
  logic [TAGW-1:0] rsp_tag;
  logic            busy;

  modport master (
    output req0_valid, req0_data, req0_tag,
    output req1_valid, req1_data, req1_tag,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_tag, busy
  );

  modport slave (
    input  req0_valid, req0_data, req0_tag,
    input  req1_valid, req1_data, req1_tag,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_tag, busy
  );

endinterface

// File: rtl/fcvt_rsp_fifo.sv
// Synchronous FIFO with register-array storage, head read straight from the array, and occupancy count.
// Latency: a push into an empty FIFO is visible at the head the next cycle.
// Backpressure: none internally; the producer must guarantee space (push while full is flagged).
module fcvt_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic                       head_vld,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full     = (count == CW'(DEPTH));
  assign head_vld = (count != '0);
  assign do_pop   = pop & head_vld;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A push into a full FIFO with no pop alongside would drop data.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full && !do_pop))
    else $error("fcvt_rsp_fifo: push into full FIFO");

endmodule

// File: rtl/ftoi.sv
// Pipelined float32 to int32 converter: magnitude rounded half away from zero, out-of-range/NaN/Inf give 0x80000000.
// Latency: NSTAGE cycles from x to y; accepts a new operand every cycle.
// Backpressure: none; the pipe has no enable and always advances.
module ftoi #(
  parameter int NSTAGE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic [7:0]  ex;
  logic [23:0] man;
  logic [31:0] half2;
  logic [31:0] mag;
  logic [31:0] res;
  logic [31:0] pipe [NSTAGE];

  // Scale the mantissa to twice the value (one fraction bit kept), then round on that bit.
  always_comb begin
    ex    = x[30:23];
    man   = {1'b1, x[22:0]};
    half2 = '0;
    mag   = '0;
    res   = '0;
    if (ex >= 8'd158) begin
      res = 32'h8000_0000;
    end else if (ex >= 8'd126) begin
      if (ex >= 8'd149) half2 = {8'd0, man} << (ex - 8'd149);
      else              half2 = {8'd0, man} >> (8'd149 - ex);
      mag = {1'b0, half2[31:1]} + {31'd0, half2[0]};
      res = x[31] ? -mag : mag;
    end
  end

  // Free-running result pipe.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NSTAGE; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= res;
      for (int i = 1; i < NSTAGE; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign y = pipe[NSTAGE-1];

endmodule

// File: rtl/fcvt_arbiter.sv
// Round-robin share of one pipelined ftoi unit between the core (0) and aux (1) requesters.
// Latency: NSTAGE+1 cycles from grant to rsp_valid; one issue per cycle while credit allows.
// Backpressure: grants are withheld unless FIFO plus in-flight entries leave a free slot, so the unit never stalls.
module fcvt_arbiter
  import fcvt_pkg::*;
#(
  parameter int NSTAGE = 1,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TAGW   = TAG_W
) (
  input  logic          clk,
  input  logic          rst,
  fcvt_arbiter_if.slave io
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(DEPTH + NSTAGE + 1);

  logic              prio;
  logic              can_issue;
  logic              take0;
  logic              take1;
  logic              issue;
  logic [31:0]       x;
  logic [31:0]       y;
  logic [NSTAGE-1:0] sh_vld;
  logic [NSTAGE-1:0] sh_id;
  logic [TAGW-1:0]   sh_tag [NSTAGE];
  logic [OW-1:0]     inflight;
  logic [OW-1:0]     occ;
  logic              push;
  logic              pop;
  logic              head_vld;
  logic [CW-1:0]     fifo_count;
  rsp_entry_t        push_ent;
  rsp_entry_t        head_ent;

  // Credit: every queued or in-flight op owns a FIFO slot; a pop this cycle frees one immediately.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < NSTAGE; i++) inflight = inflight + OW'(sh_vld[i]);
    occ       = OW'(fifo_count) + inflight - OW'(pop);
    can_issue = ~rst & (occ < OW'(DEPTH));
  end

  assign io.req0_ready = can_issue & (~io.req1_valid | (prio == REQ_CORE));
  assign io.req1_ready = can_issue & (~io.req0_valid | (prio == REQ_AUX));
  assign take0         = io.req0_valid & io.req0_ready;
  assign take1         = io.req1_valid & io.req1_ready;
  assign issue         = take0 | take1;
  assign x             = take1 ? io.req1_data : io.req0_data;

  // Priority flips to the other requester after each grant.
  always_ff @(posedge clk) begin
    if (rst)        prio <= REQ_CORE;
    else if (take0) prio <= REQ_AUX;
    else if (take1) prio <= REQ_CORE;
  end

  // Shadow pipe: {valid, id, tag} travelling alongside the operand through the unit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_vld <= '0;
      sh_id  <= '0;
      for (int i = 0; i < NSTAGE; i++) sh_tag[i] <= '0;
    end else begin
      sh_vld[0] <= issue;
      sh_id[0]  <= take1 ? REQ_AUX : REQ_CORE;
      sh_tag[0] <= take1 ? io.req1_tag : io.req0_tag;
      for (int i = 1; i < NSTAGE; i++) begin
        sh_vld[i] <= sh_vld[i-1];
        sh_id[i]  <= sh_id[i-1];
        sh_tag[i] <= sh_tag[i-1];
      end
    end
  end

  ftoi #(
    .NSTAGE (NSTAGE)
  ) u_ftoi (
    .clk  (clk),
    .rstn (~rst),
    .x    (x),
    .y    (y)
  );

  // Last shadow stage valid means y belongs to that entry; it goes straight into the FIFO.
  always_comb begin
    push_ent      = '0;
    push_ent.data = y;
    push_ent.id   = sh_id[NSTAGE-1];
    push_ent.tag  = TAG_W'(sh_tag[NSTAGE-1]);
  end

  assign push = sh_vld[NSTAGE-1];
  assign pop  = head_vld & io.rsp_ready;

  fcvt_rsp_fifo #(
    .WIDTH ($bits(rsp_entry_t)),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_vld (head_vld),
    .head_dat (head_ent),
    .count    (fifo_count)
  );

  assign io.rsp_valid = head_vld;
  assign io.rsp_data  = head_ent.data;
  assign io.rsp_id    = head_ent.id;
  assign io.rsp_tag   = head_ent.tag[TAGW-1:0];
  assign io.busy      = issue | (|sh_vld) | (fifo_count != '0);

endmodule

// File: tb/tb_fcvt_arbiter.sv
// Directed bench for fcvt_arbiter: reset, single issue, round-robin, backpressure, reset mid-flight, rounding edges, full FIFO.
// Latency: expects results NSTAGE+1 = 2 cycles after the grant.
// Backpressure: drives rsp_ready low/high per scenario and follows the req handshake.
module tb_fcvt_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   n0;
  logic [31:0] bv [4];
  logic [31:0] be [4];

  always #5 clk = ~clk;

  fcvt_arbiter_if #(.TAGW(4)) io ();

  fcvt_arbiter #(
    .NSTAGE (1),
    .DEPTH  (4),
    .TAGW   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flt(input int n);
    case (n)
      1:       flt = 32'h3F80_0000;
      2:       flt = 32'h4000_0000;
      3:       flt = 32'h4040_0000;
      4:       flt = 32'h4080_0000;
      5:       flt = 32'h40A0_0000;
      6:       flt = 32'h40C0_0000;
      7:       flt = 32'h40E0_0000;
      8:       flt = 32'h4100_0000;
      default: flt = 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    io.req0_valid = 1'b0; io.req0_data = '0; io.req0_tag = '0;
    io.req1_valid = 1'b0; io.req1_data = '0; io.req1_tag = '0;
    io.rsp_ready  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    bv[0] = 32'hC020_0000; be[0] = 32'hFFFF_FFFD;
    bv[1] = 32'h3EFF_FFFF; be[1] = 32'h0000_0000;
    bv[2] = 32'h3F00_0000; be[2] = 32'h0000_0001;
    bv[3] = 32'h4F00_0000; be[3] = 32'h8000_0000;

    // Reset values, with a request pending that must not be granted.
    rst = 1'b1;
    idle();
    io.req0_valid = 1'b1;
    step(); #1;
    chk("rst_rdy0", io.req0_ready, 0);
    chk("rst_rdy1", io.req1_ready, 0);
    chk("rst_rvld", io.rsp_valid, 0);
    chk("rst_busy", io.busy, 0);
    chk("rst_rdat", io.rsp_data, 0);
    chk("rst_rid",  io.rsp_id, 0);
    chk("rst_rtag", io.rsp_tag, 0);
    io.req0_valid = 1'b0;
    step();
    rst = 1'b0;

    // Single issue of 2.5 with tag 5.
    io.req0_valid = 1'b1; io.req0_data = 32'h4020_0000; io.req0_tag = 4'd5;
    io.rsp_ready  = 1'b1;
    #1;
    chk("t1_rdy",   io.req0_ready, 1);
    chk("t1_busy0", io.busy, 1);
    chk("t1_rvld0", io.rsp_valid, 0);
    step();
    io.req0_valid = 1'b0;
    #1;
    chk("t1_rvld1", io.rsp_valid, 0);
    chk("t1_busy1", io.busy, 1);
    step(); #1;
    chk("t1_rvld2", io.rsp_valid, 1);
    chk("t1_data",  io.rsp_data, 32'h0000_0003);
    chk("t1_id",    io.rsp_id, 0);
    chk("t1_tag",   io.rsp_tag, 5);
    chk("t1_busy2", io.busy, 1);
    step(); #1;
    chk("t1_rvld3", io.rsp_valid, 0);
    chk("t1_busy3", io.busy, 0);

    // Round-robin: req0 offers 1,3,5 and req1 offers 2,4,6 (tag = value).
    do_reset();
    io.rsp_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c < 6) begin
        io.req0_valid = 1'b1; io.req0_data = flt(2*((c+1)/2)+1); io.req0_tag = 4'(2*((c+1)/2)+1);
        io.req1_valid = 1'b1; io.req1_data = flt(2*(c/2)+2);     io.req1_tag = 4'(2*(c/2)+2);
      end else begin
        io.req0_valid = 1'b0;
        io.req1_valid = 1'b0;
      end
      #1;
      if (c < 6) begin
        chk("rr_rdy0", io.req0_ready, (c % 2 == 0));
        chk("rr_rdy1", io.req1_ready, (c % 2 == 1));
      end
      if (c >= 2 && c < 8) begin
        chk("rr_rvld", io.rsp_valid, 1);
        chk("rr_data", io.rsp_data, c - 1);
        chk("rr_id",   io.rsp_id, (c - 2) % 2);
        chk("rr_tag",  io.rsp_tag, c - 1);
      end else begin
        chk("rr_idle", io.rsp_valid, 0);
      end
      step();
    end

    // Backpressure: 1.0..5.0 on req0, consumer stalled until cycle 6.
    do_reset();
    n0 = 1;
    for (int c = 0; c < 12; c++) begin
      io.rsp_ready  = (c >= 6);
      io.req0_valid = (n0 <= 5);
      io.req0_data  = flt(n0);
      io.req0_tag   = 4'(n0);
      #1;
      if (c <= 6) chk("bp_rdy", io.req0_ready, (c < 4 || c == 6));
      if (c < 2 || c == 11) begin
        chk("bp_rvld0", io.rsp_valid, 0);
      end else begin
        chk("bp_rvld", io.rsp_valid, 1);
        chk("bp_data", io.rsp_data, (c < 6) ? 1 : c - 5);
      end
      if (io.req0_valid && io.req0_ready) n0++;
      step();
    end

    // Reset with two results queued and one in flight.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      io.req0_valid = 1'b1; io.req0_data = flt(c + 1); io.req0_tag = 4'(c + 1);
      #1;
      chk("mr_fill", io.req0_ready, 1);
      step();
    end
    rst = 1'b1;
    io.req1_valid = 1'b1; io.req1_data = flt(2); io.req1_tag = 4'd2;
    #1;
    chk("mr_rst_rdy", io.req0_ready, 0);
    step();
    rst = 1'b0;
    io.req0_valid = 1'b0;
    io.req1_valid = 1'b0;
    #1;
    chk("mr_rvld", io.rsp_valid, 0);
    chk("mr_busy", io.busy, 0);
    io.req0_valid = 1'b1; io.req0_data = flt(7); io.req0_tag = 4'd9;
    io.req1_valid = 1'b1; io.req1_data = flt(8); io.req1_tag = 4'd10;
    io.rsp_ready  = 1'b1;
    #1;
    chk("mr_gnt0", io.req0_ready, 1);
    chk("mr_gnt1", io.req1_ready, 0);
    step();
    io.req0_valid = 1'b0;
    io.req1_valid = 1'b0;
    for (int c = 1; c < 6; c++) begin
      #1;
      chk("mr_post_rvld", io.rsp_valid, (c == 2));
      if (c == 2) begin
        chk("mr_post_data", io.rsp_data, 7);
        chk("mr_post_id",   io.rsp_id, 0);
        chk("mr_post_tag",  io.rsp_tag, 9);
      end
      step();
    end

    // Rounding and range boundaries.
    do_reset();
    io.rsp_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        io.req0_valid = 1'b1; io.req0_data = bv[c]; io.req0_tag = 4'(c);
      end else begin
        io.req0_valid = 1'b0;
      end
      #1;
      if (c < 4) chk("bd_rdy", io.req0_ready, 1);
      if (c >= 2 && c < 6) begin
        chk("bd_rvld", io.rsp_valid, 1);
        chk("bd_data", io.rsp_data, be[c-2]);
      end else begin
        chk("bd_idle", io.rsp_valid, 0);
      end
      step();
    end

    // FIFO held at DEPTH-1 with one in flight while pushing and popping together.
    do_reset();
    n0 = 1;
    for (int c = 0; c < 13; c++) begin
      io.rsp_ready  = (c >= 4);
      io.req0_valid = (n0 <= 8);
      io.req0_data  = flt(n0);
      io.req0_tag   = 4'(n0);
      #1;
      if (c <= 7) chk("ff_rdy", io.req0_ready, 1);
      if (c < 2 || c == 12) begin
        chk("ff_rvld0", io.rsp_valid, 0);
      end else begin
        chk("ff_rvld", io.rsp_valid, 1);
        chk("ff_data", io.rsp_data, (c < 4) ? 1 : c - 3);
      end
      if (c == 12) chk("ff_busy", io.busy, 0);
      if (io.req0_valid && io.req0_ready) n0++;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
